sdram_arbiter: RTL and testbench

- Shares the single SDRAM command port between three requesters: the SPI flash-emulation read path, the host/UART glue (read/write), and periodic refresh.
- Sits between spi_trx/glue and the sdram core, replacing their direct per-requester command wiring.
- The SPI path is latency-critical and wins over the host; refresh is scheduled around SPI bursts but is never allowed to become overdue.

---
 rtl/sdram_arb_pkg.sv | 25 ++
 rtl/refresh_timer.sv | 48 ++++
 rtl/sdram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared encodings and types for the SDRAM command-port arbiter.
// Command codes match the sdram core's mem_cmd field.
package sdram_arb_pkg;

    localparam logic [1:0] CMD_NONE    = 2'b00;
    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_REFRESH = 2'b11;

    localparam int FAIRNESS_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_SPI,
        SRC_HOST,
        SRC_REF
    } src_e;

endpackage

// File: rtl/refresh_timer.sv
// Refresh tick generator with a saturating count of owed refreshes
// and a sticky flag for ticks that arrive while the count is full.
module refresh_timer #(
    parameter int REFRESH_CYCLES = 1040
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    output logic [3:0] pending,
    output logic       overrun
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] count;
    logic          tick;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // A tick and an issue in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 4'd0;
            overrun <= 1'b0;
        end else begin
            if (tick && !issue && pending != 4'hF) begin
                pending <= pending + 4'd1;
            end else if (!tick && issue && pending != 4'd0) begin
                pending <= pending - 4'd1;
            end
            if (tick && pending == 4'hF) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM command port between the SPI read path,
// the host glue and periodic refresh.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1040,
    parameter int MAX_PENDING    = 8,
    parameter int ADDR_W         = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_req,
    input  logic [21:0]       spi_addr,
    input  logic              spi_inhibit_refresh,
    output logic              spi_gnt,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              mem_valid,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_busy,
    input  logic              mem_done,
    output logic [3:0]        refresh_pending,
    output logic              refresh_overrun
);

    localparam logic [3:0] URGENT_LVL = 4'(MAX_PENDING);
    localparam logic [2:0] FAIR_MAX   = 3'(FAIRNESS_LIMIT);

    state_e            state, state_d;
    src_e              src_q, src_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load;
    logic              accept;
    logic              ref_issue;
    logic              urgent;
    logic              ref_ok;
    logic              host_turn;
    logic [2:0]        fair_cnt;

    refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .reset  (reset),
        .issue  (ref_issue),
        .pending(refresh_pending),
        .overrun(refresh_overrun)
    );

    assign urgent    = (refresh_pending >= URGENT_LVL);
    assign ref_ok    = (refresh_pending != 4'd0) && !spi_inhibit_refresh;
    assign host_turn = host_req && (fair_cnt >= FAIR_MAX);

    // Candidate selection; only consumed while IDLE.
    always_comb begin
        src_d  = SRC_NONE;
        cmd_d  = CMD_NONE;
        addr_d = '0;
        if (urgent) begin
            src_d = SRC_REF;
            cmd_d = CMD_REFRESH;
        end else if (host_turn) begin
            src_d  = SRC_HOST;
            cmd_d  = host_we ? CMD_WRITE : CMD_READ;
            addr_d = host_addr;
        end else if (spi_req) begin
            src_d  = SRC_SPI;
            cmd_d  = CMD_READ;
            addr_d = ADDR_W'({spi_addr, 2'b00});
        end else if (ref_ok) begin
            src_d = SRC_REF;
            cmd_d = CMD_REFRESH;
        end else if (host_req) begin
            src_d  = SRC_HOST;
            cmd_d  = host_we ? CMD_WRITE : CMD_READ;
            addr_d = host_addr;
        end
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (src_d != SRC_NONE) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_busy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= SRC_NONE;
            cmd_q  <= CMD_NONE;
            addr_q <= '0;
        end else if (load) begin
            src_q  <= src_d;
            cmd_q  <= cmd_d;
            addr_q <= addr_d;
        end
    end

    assign accept    = (state == ISSUE) && !mem_busy;
    assign mem_valid = (state == ISSUE);
    assign mem_cmd   = mem_valid ? cmd_q : CMD_NONE;
    assign mem_addr  = mem_valid ? addr_q : '0;
    assign spi_gnt   = accept && (src_q == SRC_SPI);
    assign host_gnt  = accept && (src_q == SRC_HOST);
    assign ref_issue = accept && (src_q == SRC_REF);

    // Counts SPI grants taken while the host is left waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fair_cnt <= 3'd0;
        end else if (host_gnt) begin
            fair_cnt <= 3'd0;
        end else if (spi_gnt && host_req && fair_cnt != FAIR_MAX) begin
            fair_cnt <= fair_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a simple responding core model.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int RC = 1040;
    localparam int AW = 24;

    logic          clk;
    logic          reset;
    logic          spi_req;
    logic [21:0]   spi_addr;
    logic          spi_inhibit_refresh;
    logic          spi_gnt;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic          host_gnt;
    logic          mem_valid;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic          mem_busy;
    logic          mem_done;
    logic [3:0]    refresh_pending;
    logic          refresh_overrun;

    sdram_arbiter #(
        .REFRESH_CYCLES(RC),
        .MAX_PENDING   (8),
        .ADDR_W        (AW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .spi_req            (spi_req),
        .spi_addr           (spi_addr),
        .spi_inhibit_refresh(spi_inhibit_refresh),
        .spi_gnt            (spi_gnt),
        .host_req           (host_req),
        .host_we            (host_we),
        .host_addr          (host_addr),
        .host_gnt           (host_gnt),
        .mem_valid          (mem_valid),
        .mem_cmd            (mem_cmd),
        .mem_addr           (mem_addr),
        .mem_busy           (mem_busy),
        .mem_done           (mem_done),
        .refresh_pending    (refresh_pending),
        .refresh_overrun    (refresh_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int done_dly = 1;
    int done_cnt = 0;
    bit spi_hold = 0;
    bit host_hold = 0;
    int valid_cnt = 0;
    int spi_gnt_cnt = 0;
    int host_gnt_cnt = 0;

    logic [1:0]    log_cmd[$];
    logic [AW-1:0] log_addr[$];
    byte           log_src[$];
    int            log_cyc[$];

    task automatic clear_log();
        log_cmd.delete();
        log_addr.delete();
        log_src.delete();
        log_cyc.delete();
    endtask

    // Core model: accepts when not busy, pulses mem_done done_dly cycles later.
    task automatic core_model();
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (reset) begin
                done_cnt = 0;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) mem_done = 1'b1;
            end
            if (mem_valid) valid_cnt++;
            if (spi_gnt) spi_gnt_cnt++;
            if (host_gnt) host_gnt_cnt++;
            if (mem_valid && !mem_busy && !reset) begin
                log_cmd.push_back(mem_cmd);
                log_addr.push_back(mem_addr);
                log_src.push_back(spi_gnt ? "S" : (host_gnt ? "H" : "R"));
                log_cyc.push_back(cyc);
                done_cnt = done_dly;
                if (spi_gnt && !spi_hold) spi_req = 1'b0;
                if (host_gnt && !host_hold) host_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_valid, spi_gnt, host_gnt, refresh_overrun} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {mem_valid, spi_gnt, host_gnt, refresh_overrun});
        end
        n_checks++;
        if (mem_cmd !== 2'b00 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd: got cmd %b addr %h want 0/0", mem_cmd, mem_addr);
        end
        n_checks++;
        if (refresh_pending !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pending: got %0d want 0", refresh_pending);
        end
        reset = 1'b0;
    endtask

    task automatic test_refresh_idle();
        int v0;
        v0 = valid_cnt;
        repeat (2 * RC + 2) @(negedge clk);
        n_checks++;
        if (refresh_pending !== 4'd2) begin
            n_fail++;
            $display("FAIL idle_pending: got %0d want 2", refresh_pending);
        end
        n_checks++;
        if (valid_cnt != v0) begin
            n_fail++;
            $display("FAIL idle_valid: got %0d valid cycles want 0", valid_cnt - v0);
        end
    endtask

    task automatic test_refresh_issue();
        int g0;
        bit ok;
        clear_log();
        g0 = spi_gnt_cnt + host_gnt_cnt;
        spi_inhibit_refresh = 1'b0;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (refresh_pending == 4'd0 && log_cmd.size() >= 2) begin
                ok = 1;
                break;
            end
        end
        repeat (5) @(negedge clk);
        spi_inhibit_refresh = 1'b1;
        n_checks++;
        if (!ok || log_cmd.size() != 2) begin
            n_fail++;
            $display("FAIL refresh_count: got %0d cmds (done=%0d) want 2", log_cmd.size(), ok);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (log_cmd[i] !== CMD_REFRESH || log_addr[i] !== '0) begin
                    n_fail++;
                    $display("FAIL refresh_cmd%0d: got %b/%h want 11/0", i, log_cmd[i], log_addr[i]);
                end
            end
        end
        n_checks++;
        if (refresh_pending !== 4'd0) begin
            n_fail++;
            $display("FAIL refresh_pending: got %0d want 0", refresh_pending);
        end
        n_checks++;
        if (spi_gnt_cnt + host_gnt_cnt != g0) begin
            n_fail++;
            $display("FAIL refresh_gnt: got %0d gnt pulses want 0", spi_gnt_cnt + host_gnt_cnt - g0);
        end
    endtask

    task automatic test_spi_host_priority();
        bit ok;
        clear_log();
        @(posedge clk);
        #1;
        spi_addr  = 22'h12345;
        host_addr = 24'h00ABCD;
        host_we   = 1'b0;
        spi_req   = 1'b1;
        host_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_valid !== 1'b1 || mem_cmd !== CMD_READ || mem_addr !== 24'h048D14 || spi_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL spi_latency: got v%b cmd %b addr %h gnt %b want 1 01 048d14 1",
                     mem_valid, mem_cmd, mem_addr, spi_gnt);
        end
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (log_cmd.size() >= 2) begin
                ok = 1;
                break;
            end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL prio_timeout: got %0d cmds want 2", log_cmd.size());
        end else begin
            n_checks++;
            if (log_src[1] !== "H" || log_cmd[1] !== CMD_READ || log_addr[1] !== 24'h00ABCD) begin
                n_fail++;
                $display("FAIL prio_host: got %c %b %h want H 01 00abcd", log_src[1], log_cmd[1], log_addr[1]);
            end
            n_checks++;
            if (log_cyc[1] - log_cyc[0] != 3) begin
                n_fail++;
                $display("FAIL prio_spacing: got %0d cycles want 3", log_cyc[1] - log_cyc[0]);
            end
        end
    endtask

    task automatic test_fairness();
        string exp_seq;
        bit ok;
        exp_seq = "SSSSHS";
        clear_log();
        @(posedge clk);
        #1;
        spi_hold  = 1'b1;
        spi_addr  = 22'h00010;
        spi_req   = 1'b1;
        host_we   = 1'b1;
        host_addr = 24'h55AA55;
        host_req  = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (log_cmd.size() >= 6) begin
                ok = 1;
                break;
            end
        end
        spi_req  = 1'b0;
        spi_hold = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fair_timeout: got %0d grants want 6", log_cmd.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (log_src[i] !== exp_seq[i]) begin
                    n_fail++;
                    $display("FAIL fair_seq%0d: got %c want %c", i, log_src[i], exp_seq[i]);
                end
            end
            n_checks++;
            if (log_cmd[4] !== CMD_WRITE || log_addr[4] !== 24'h55AA55 || log_addr[0] !== 24'h000040) begin
                n_fail++;
                $display("FAIL fair_cmd: got host %b/%h spi %h want 10/55aa55 000040",
                         log_cmd[4], log_addr[4], log_addr[0]);
            end
        end
    endtask

    task automatic test_busy_hold();
        int h0;
        clear_log();
        h0 = host_gnt_cnt;
        @(posedge clk);
        #1;
        mem_busy  = 1'b1;
        host_we   = 1'b1;
        host_addr = 24'hABCDEF;
        host_req  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_valid !== 1'b1 || mem_cmd !== CMD_WRITE || mem_addr !== 24'hABCDEF || host_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_hold%0d: got v%b %b %h gnt %b want 1 10 abcdef 0",
                         i, mem_valid, mem_cmd, mem_addr, host_gnt);
            end
        end
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (host_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_accept: got gnt %b want 1", host_gnt);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (host_gnt_cnt - h0 != 1 || log_cmd.size() != 1) begin
            n_fail++;
            $display("FAIL busy_single: got %0d gnts %0d cmds want 1 1", host_gnt_cnt - h0, log_cmd.size());
        end
    endtask

    task automatic test_urgent_refresh();
        int  n;
        int  r_before;
        bit  ok;
        clear_log();
        spi_inhibit_refresh = 1'b1;
        spi_hold = 1'b1;
        spi_addr = 22'h3FFFFF;
        spi_req  = 1'b1;
        ok = 0;
        for (int i = 0; i < 9 * RC + 50; i++) begin
            @(negedge clk);
            if (refresh_pending >= 4'd8) begin
                ok = 1;
                break;
            end
        end
        n = log_cmd.size();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL urgent_timeout: got pending %0d want 8", refresh_pending);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (log_cmd.size() >= n + 2) break;
        end
        spi_req  = 1'b0;
        spi_hold = 1'b0;
        repeat (10) @(negedge clk);
        r_before = 0;
        for (int i = 0; i < n; i++) begin
            if (log_cmd[i] == CMD_REFRESH) r_before++;
        end
        n_checks++;
        if (r_before != 0 || n == 0 || log_addr[0] !== 24'hFFFFFC) begin
            n_fail++;
            $display("FAIL urgent_inhibit: got %0d refreshes before urgent, addr %h want 0 fffffc",
                     r_before, (n > 0) ? log_addr[0] : 24'h0);
        end
        n_checks++;
        if (log_cmd.size() < n + 2 ||
            !(log_cmd[n] == CMD_REFRESH || (log_src[n] == "S" && log_cmd[n + 1] == CMD_REFRESH))) begin
            n_fail++;
            $display("FAIL urgent_order: got %0d cmds after urgent want refresh before next spi read",
                     log_cmd.size() - n);
        end
        n_checks++;
        if (refresh_pending !== 4'd7) begin
            n_fail++;
            $display("FAIL urgent_pending: got %0d want 7", refresh_pending);
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        clear_log();
        done_dly = 20;
        @(posedge clk);
        #1;
        spi_addr = 22'h00001;
        spi_req  = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spi_gnt) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (!ok || refresh_pending == 4'd0) begin
            n_fail++;
            $display("FAIL rstwait_setup: got gnt %0d pending %0d want 1 nonzero", ok, refresh_pending);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_valid, spi_gnt, host_gnt, refresh_overrun} !== 4'b0 || mem_cmd !== 2'b00 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL rstwait_out: got %b cmd %b addr %h want 0",
                     {mem_valid, spi_gnt, host_gnt, refresh_overrun}, mem_cmd, mem_addr);
        end
        n_checks++;
        if (refresh_pending !== 4'd0) begin
            n_fail++;
            $display("FAIL rstwait_pending: got %0d want 0", refresh_pending);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        done_dly = 1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (log_cmd.size() != 1 || mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_quiet: got %0d cmds valid %b want 1 0", log_cmd.size(), mem_valid);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        spi_inhibit_refresh = 1'b1;
        mem_busy = 1'b1;
        ok = 0;
        for (int i = 0; i < 16 * RC + 100; i++) begin
            @(negedge clk);
            if (refresh_pending == 4'hF) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok || refresh_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_reach: got pending %0d overrun %b want 15 0", refresh_pending, refresh_overrun);
        end
        n_checks++;
        if (mem_valid !== 1'b1 || mem_cmd !== CMD_REFRESH) begin
            n_fail++;
            $display("FAIL sat_stuck: got v%b cmd %b want 1 11", mem_valid, mem_cmd);
        end
        ok = 0;
        for (int i = 0; i < RC + 10; i++) begin
            @(negedge clk);
            if (refresh_overrun) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok || refresh_pending !== 4'hF) begin
            n_fail++;
            $display("FAIL overrun_set: got overrun %0d pending %0d want 1 15", ok, refresh_pending);
        end
        reset = 1'b1;
        mem_busy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        spi_req = 1'b0;
        spi_addr = '0;
        spi_inhibit_refresh = 1'b1;
        host_req = 1'b0;
        host_we = 1'b0;
        host_addr = '0;
        mem_busy = 1'b0;
        mem_done = 1'b0;
        fork
            core_model();
        join_none
        test_reset();
        test_refresh_idle();
        test_refresh_issue();
        test_spi_host_priority();
        test_fairness();
        test_busy_hold();
        test_urgent_refresh();
        test_reset_in_wait();
        test_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
